// File: rtl/ledoverride.sv
// LED output stage: passes the bouncer pattern through unless the CPU has taken
// ownership of an LED over Wishbone, in which case that LED shows a 5-bit PWM level.
module ledoverride #(
  parameter int NLEDS  = 8,
  parameter int TOBITS = 27,
  parameter int AW     = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [31:0]       i_wb_data,
  input  logic [3:0]        i_wb_sel,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_data,
  input  logic [NLEDS-1:0]  i_leds,
  output logic [NLEDS-1:0]  o_leds
);

  // Handshake: a request is cyc&&stb, accepted on every clock (stall is tied low);
  // each request gets exactly one ack on the following clock, with read data alongside.
  logic              req, wr, fire;
  logic [NLEDS-1:0]  mask;
  logic              toen, toflag;
  logic [4:0]        br [NLEDS];
  logic [TOBITS-1:0] tc;
  logic [4:0]        pc, brev;
  logic [NLEDS-1:0]  pwm;
  logic [31:0]       rdata;
  logic              unused_ok;

  assign o_wb_stall = 1'b0;
  assign req        = i_wb_cyc && i_wb_stb;
  assign wr         = req && i_wb_we;
  assign fire       = (tc == '0) && toen && (mask != '0) && !wr;
  assign brev       = {pc[0], pc[1], pc[2], pc[3], pc[4]};
  assign unused_ok  = &{1'b0, i_wb_sel, i_wb_data};

  // Bit-reversed compare spreads the on-time evenly across the 32-clock period.
  always_comb begin
    pwm = '0;
    for (int k = 0; k < NLEDS; k++)
      pwm[k] = (br[k] == 5'd31) || ((br[k] != 5'd0) && (brev < br[k]));
  end

  always_comb begin
    rdata = '0;
    if (i_wb_addr == '0) begin
      rdata[NLEDS-1:0] = mask;
      rdata[31]        = toen;
      rdata[30]        = toflag;
    end
    for (int k = 0; k < NLEDS; k++)
      if (i_wb_addr == AW'(k + 1)) rdata[4:0] = br[k];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mask      <= '0;
      toen      <= 1'b0;
      toflag    <= 1'b0;
      tc        <= '0;
      pc        <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      o_leds    <= '0;
      for (int k = 0; k < NLEDS; k++) br[k] <= '0;
    end else begin
      o_wb_ack  <= req;
      o_wb_data <= req ? rdata : 32'd0;
      pc        <= pc + 5'd1;
      for (int k = 0; k < NLEDS; k++)
        o_leds[k] <= mask[k] ? pwm[k] : i_leds[k];
      if (wr) begin
        // Any write counts as CPU activity, whatever the address.
        tc <= '1;
        if (i_wb_addr == '0) begin
          mask   <= i_wb_data[NLEDS-1:0];
          toen   <= i_wb_data[31];
          toflag <= 1'b0;
        end
        for (int k = 0; k < NLEDS; k++)
          if (i_wb_addr == AW'(k + 1)) br[k] <= i_wb_data[4:0];
      end else begin
        if (tc != '0) tc <= tc - 1'b1;
        if (fire) begin
          mask   <= '0;
          toflag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ledoverride.sv
// Randomized and directed bench for ledoverride, checked cycle by cycle against
// a behavioural model of the register map, PWM duty and idle timeout.
module tb_ledoverride;
  localparam int NLEDS  = 8;
  localparam int TOBITS = 4;
  localparam int AW     = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_reset, i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-1:0]     i_wb_addr;
  logic [31:0]       i_wb_data;
  logic [3:0]        i_wb_sel;
  logic              o_wb_stall, o_wb_ack;
  logic [31:0]       o_wb_data;
  logic [NLEDS-1:0]  i_leds, o_leds;

  ledoverride #(.NLEDS(NLEDS), .TOBITS(TOBITS), .AW(AW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_wb_sel(i_wb_sel), .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack),
    .o_wb_data(o_wb_data), .i_leds(i_leds), .o_leds(o_leds)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  logic [NLEDS-1:0] m_mask;
  bit               m_toen, m_toflag;
  int               m_br [NLEDS];
  int               m_tc, m_pc;
  bit               exp_ack;
  logic [NLEDS-1:0] exp_leds;
  bit               have_exp = 0;
  logic [31:0]      exp_q [$];
  logic [31:0]      last_data;
  logic [NLEDS-1:0] last_leds;

  function automatic int brev5(input int p);
    int r = 0;
    for (int i = 0; i < 5; i++) if (p[i]) r = r | (1 << (4 - i));
    return r;
  endfunction

  function automatic bit pwm_level(input int b, input int p);
    if (b == 31) return 1'b1;
    if (b == 0) return 1'b0;
    return brev5(p) < b;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r = '0;
    if (a == 0) begin
      r[NLEDS-1:0] = m_mask;
      r[31] = m_toen;
      r[30] = m_toflag;
    end else if (a <= NLEDS) begin
      r = 32'(m_br[a-1]);
    end
    return r;
  endfunction

  // driver: one call per clock; checks the previous clock's outputs, drives, predicts
  task automatic step(input bit rst, input bit cyc, input bit stb, input bit we,
                      input int addr, input logic [31:0] data, input logic [NLEDS-1:0] leds);
    bit req, wr, fire;
    @(negedge clk);
    if (have_exp) begin
      check("ack", 32'(o_wb_ack), 32'(exp_ack));
      check("leds", 32'(o_leds), 32'(exp_leds));
      if (exp_ack && exp_q.size() > 0) check("rdata", o_wb_data, exp_q.pop_front());
      check("stall", 32'(o_wb_stall), 32'd0);
      last_data = o_wb_data;
      last_leds = o_leds;
    end
    i_reset   = rst;
    i_wb_cyc  = cyc;
    i_wb_stb  = stb;
    i_wb_we   = we;
    i_wb_addr = AW'(addr);
    i_wb_data = data;
    i_wb_sel  = 4'($urandom_range(0, 15));
    i_leds    = leds;
    req = cyc && stb;
    wr  = req && we;
    if (rst) begin
      exp_ack = 0; exp_leds = '0; m_mask = '0; m_toen = 0; m_toflag = 0;
      m_tc = 0; m_pc = 0;
      for (int k = 0; k < NLEDS; k++) m_br[k] = 0;
      exp_q.delete();
    end else begin
      exp_ack = req;
      if (req) exp_q.push_back(model_read(addr));
      for (int k = 0; k < NLEDS; k++)
        exp_leds[k] = m_mask[k] ? pwm_level(m_br[k], m_pc) : leds[k];
      fire = (m_tc == 0) && m_toen && (m_mask != 0) && !wr;
      if (wr) begin
        m_tc = (1 << TOBITS) - 1;
        if (addr == 0) begin
          m_mask = data[NLEDS-1:0]; m_toen = data[31]; m_toflag = 0;
        end else if (addr <= NLEDS) begin
          m_br[addr-1] = int'(data[4:0]);
        end
      end else begin
        if (fire) begin m_mask = '0; m_toflag = 1; end
        if (m_tc > 0) m_tc--;
      end
      m_pc = (m_pc + 1) % 32;
    end
    have_exp = 1;
    @(posedge clk);
  endtask

  task automatic idle(input logic [NLEDS-1:0] leds);
    step(0, 0, 0, 0, 0, 32'd0, leds);
  endtask

  task automatic wb_write(input int addr, input logic [31:0] data);
    step(0, 1, 1, 1, addr, data, NLEDS'($urandom));
  endtask

  // read, then one idle clock so the acked data lands in last_data
  task automatic wb_read(input int addr, output logic [31:0] data);
    step(0, 1, 1, 0, addr, 32'($urandom), NLEDS'($urandom));
    idle(NLEDS'($urandom));
    data = last_data;
  endtask

  logic [31:0] rd;
  int          hi_cnt;
  int          dens;

  initial begin
    step(1, 0, 0, 0, 0, 32'd0, '0);
    step(1, 0, 0, 0, 0, 32'd0, '0);
    idle(8'h5A);
    idle(8'h5A);
    check("passthrough_5a", 32'(last_leds), 32'h5A);
    wb_read(0, rd);
    check("ctrl_after_reset", rd, 32'h0);

    // forced on/off
    wb_write(0, 32'h81);
    wb_write(1, 32'd31);
    wb_write(8, 32'd0);
    for (int i = 0; i < 40; i++) idle(NLEDS'($urandom));
    check("led0_forced_on", 32'(last_leds[0]), 32'd1);
    check("led7_forced_off", 32'(last_leds[7]), 32'd0);

    // duty of brightness 8
    wb_write(1, 32'd8);
    idle('0);
    hi_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      idle(NLEDS'($urandom));
      hi_cnt += int'(last_leds[0]);
    end
    check("duty_8_of_32", 32'(hi_cnt), 32'd8);
    for (int a = 0; a < 10; a++) step(0, 1, 1, 0, a, 32'd0, NLEDS'($urandom));
    idle('0);
    check("addr9_reads_0", last_data, 32'h0);

    // timeout fires 16 clocks after the last write
    wb_write(0, 32'h80000003);
    for (int i = 0; i < 16; i++) idle(NLEDS'($urandom));
    wb_read(0, rd);
    check("timeout_ctrl", rd, 32'hC0000000);

    // a write on the firing clock wins
    wb_write(0, 32'h80000003);
    for (int i = 0; i < 15; i++) idle(NLEDS'($urandom));
    wb_write(1, 32'd5);
    wb_read(0, rd);
    check("write_beats_timeout", rd, 32'h80000003);

    // no timeout with TOEN clear; CTRL write clears TOFLAG
    wb_write(0, 32'hFF);
    for (int i = 0; i < 40; i++) idle(NLEDS'($urandom));
    wb_read(0, rd);
    check("toen_off_holds", rd, 32'h000000FF);
    wb_write(0, 32'h80000001);
    for (int i = 0; i < 20; i++) idle(NLEDS'($urandom));
    wb_write(0, 32'h1);
    wb_read(0, rd);
    check("toflag_cleared", rd, 32'h1);

    // reset beats a simultaneous write
    step(1, 1, 1, 1, 0, 32'hFF, 8'hFF);
    idle(8'hC3);
    check("reset_no_ack", 32'(o_wb_ack), 32'd0);
    check("reset_leds_zero", 32'(last_leds), 32'h0);
    idle(8'h3C);
    check("passthrough_after_reset", 32'(last_leds), 32'hC3);

    // randomized traffic with bursty density so timeouts get a chance to fire
    for (int blk = 0; blk < 40; blk++) begin
      dens = $urandom_range(0, 4);
      for (int i = 0; i < 48; i++) begin
        if ($urandom_range(0, 299) == 0)
          step(1, 1, 1, 1, 0, 32'($urandom), NLEDS'($urandom));
        else
          step(0, $urandom_range(0, 7) < dens + 1, $urandom_range(0, 7) < dens,
               $urandom_range(0, 1) == 1, $urandom_range(0, 15),
               ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 40)),
               NLEDS'($urandom));
      end
      for (int i = 0; i < ($urandom_range(0, 1) == 1 ? 20 : 2); i++) idle(NLEDS'($urandom));
    end
    idle('0);
    idle('0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
